// File: rtl/issue_queue_pkg.sv
// ============================================================================
// Module   : issue_queue_pkg
// Purpose  : Shared defaults and opcode constants for the issue queue slice.
// Contents : Default widths/depth for issue_queue and the RV64 major opcode
//            encodings used by dispatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_queue_pkg;

  localparam int OPCODE_WIDTH_DEF = 7;
  localparam int ISSUE_DEPTH_DEF  = 16;
  localparam int AGE_WIDTH_DEF    = 5;
  localparam int PREG_WIDTH_DEF   = 7;

  // RV64 major opcodes (instruction bits [6:0]).
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

endpackage

`default_nettype wire

// File: rtl/iq_free_finder.sv
// ============================================================================
// Module   : iq_free_finder
// Purpose  : Lowest-index-first priority encoder over the free-slot vector.
// Ports    : free_i  - one bit per slot, 1 = slot is free
//            idx_o   - index of the lowest free slot (0 when none found)
//            found_o - at least one slot is free
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_free_finder
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = ISSUE_DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] free_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/issue_queue.sv
// ============================================================================
// Module   : issue_queue
// Purpose  : Out-of-order issue queue between rename/dispatch and the issue
//            arbiter. Holds renamed instructions, tracks operand readiness
//            from writeback wakeups and keeps a dense relative age per entry
//            (0 = oldest) for the arbiter.
// Ports    : clk/rst_n            - clock, synchronous active-low reset
//            flush                - drop every entry
//            disp_*               - dispatch handshake and payload
//            wb_valid/wb_pdst     - wakeup broadcast
//            iq_op/iq_req/iq_age  - registered per-entry view for the arbiter
//            grant/grant_addr     - arbiter selection
//            iss_*                - combinational payload of the granted entry
//            count                - number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int ISSUE_DEPTH  = ISSUE_DEPTH_DEF,
  parameter int AGE_WIDTH    = AGE_WIDTH_DEF,
  parameter int PREG_WIDTH   = PREG_WIDTH_DEF,
  parameter int IDX_W        = $clog2(ISSUE_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [OPCODE_WIDTH-1:0]           disp_op,
  input  logic [PREG_WIDTH-1:0]             disp_psrc1,
  input  logic [PREG_WIDTH-1:0]             disp_psrc2,
  input  logic                              disp_src1_rdy,
  input  logic                              disp_src2_rdy,
  input  logic [PREG_WIDTH-1:0]             disp_pdst,
  input  logic                              wb_valid,
  input  logic [PREG_WIDTH-1:0]             wb_pdst,
  output logic [ISSUE_DEPTH*OPCODE_WIDTH-1:0] iq_op,
  output logic [ISSUE_DEPTH-1:0]            iq_req,
  output logic [ISSUE_DEPTH*AGE_WIDTH-1:0]  iq_age,
  input  logic                              grant,
  input  logic [IDX_W-1:0]                  grant_addr,
  output logic                              iss_valid,
  output logic [OPCODE_WIDTH-1:0]           iss_op,
  output logic [PREG_WIDTH-1:0]             iss_psrc1,
  output logic [PREG_WIDTH-1:0]             iss_psrc2,
  output logic [PREG_WIDTH-1:0]             iss_pdst,
  output logic [AGE_WIDTH-1:0]              count
);

  // Entry state
  logic [ISSUE_DEPTH-1:0]  valid_q, valid_d;
  logic [ISSUE_DEPTH-1:0]  rdy1_q, rdy1_d;
  logic [ISSUE_DEPTH-1:0]  rdy2_q, rdy2_d;
  logic [OPCODE_WIDTH-1:0] op_q    [ISSUE_DEPTH];
  logic [OPCODE_WIDTH-1:0] op_d    [ISSUE_DEPTH];
  logic [PREG_WIDTH-1:0]   psrc1_q [ISSUE_DEPTH];
  logic [PREG_WIDTH-1:0]   psrc1_d [ISSUE_DEPTH];
  logic [PREG_WIDTH-1:0]   psrc2_q [ISSUE_DEPTH];
  logic [PREG_WIDTH-1:0]   psrc2_d [ISSUE_DEPTH];
  logic [PREG_WIDTH-1:0]   pdst_q  [ISSUE_DEPTH];
  logic [PREG_WIDTH-1:0]   pdst_d  [ISSUE_DEPTH];
  logic [AGE_WIDTH-1:0]    age_q   [ISSUE_DEPTH];
  logic [AGE_WIDTH-1:0]    age_d   [ISSUE_DEPTH];
  logic [AGE_WIDTH-1:0]    count_q, count_d;

  // Control
  logic                    issue_fire;
  logic                    disp_fire;
  logic [IDX_W-1:0]        free_idx;
  logic                    free_found;
  logic [AGE_WIDTH-1:0]    grant_age;
  logic [AGE_WIDTH-1:0]    disp_age;
  logic                    disp_rdy1;
  logic                    disp_rdy2;
  logic [ISSUE_DEPTH-1:0]  wake1;
  logic [ISSUE_DEPTH-1:0]  wake2;
  logic [ISSUE_DEPTH-1:0]  age_dec;

  // Searching ~valid_q (not the next-state) keeps a slot freed by this
  // cycle's issue out of reach until the following cycle.
  iq_free_finder #(
    .DEPTH (ISSUE_DEPTH),
    .IDX_W (IDX_W)
  ) u_free_finder (
    .free_i  (~valid_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  assign issue_fire = grant & valid_q[grant_addr];
  assign grant_age  = age_q[grant_addr];
  assign disp_ready = (count_q != AGE_WIDTH'(ISSUE_DEPTH));
  assign disp_fire  = disp_valid & disp_ready & free_found;
  // The issuing entry leaves at the same edge, so the newcomer sits one lower.
  assign disp_age   = count_q - AGE_WIDTH'(issue_fire);
  // Same-cycle wakeup must be captured for the entry being written.
  assign disp_rdy1  = disp_src1_rdy | (wb_valid & (wb_pdst == disp_psrc1));
  assign disp_rdy2  = disp_src2_rdy | (wb_valid & (wb_pdst == disp_psrc2));

  generate
    for (genvar i = 0; i < ISSUE_DEPTH; i++) begin : g_entry
      assign wake1[i]   = wb_valid & valid_q[i] & (psrc1_q[i] == wb_pdst);
      assign wake2[i]   = wb_valid & valid_q[i] & (psrc2_q[i] == wb_pdst);
      // Entries younger than the issued one close the gap in the age order.
      assign age_dec[i] = issue_fire & valid_q[i] & (age_q[i] > grant_age);

      assign iq_req[i]                              = valid_q[i] & rdy1_q[i] & rdy2_q[i];
      assign iq_op[i*OPCODE_WIDTH +: OPCODE_WIDTH] = op_q[i];
      // Ages are zeroed whenever an entry leaves, so invalid slots read 0.
      assign iq_age[i*AGE_WIDTH +: AGE_WIDTH]       = age_q[i];
    end
  endgenerate

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    op_d    = op_q;
    psrc1_d = psrc1_q;
    psrc2_d = psrc2_q;
    pdst_d  = pdst_q;
    age_d   = age_q;
    count_d = count_q + AGE_WIDTH'(disp_fire) - AGE_WIDTH'(issue_fire);

    for (int i = 0; i < ISSUE_DEPTH; i++) begin
      if (age_dec[i]) age_d[i] = age_q[i] - AGE_WIDTH'(1);
      if (wake1[i])   rdy1_d[i] = 1'b1;
      if (wake2[i])   rdy2_d[i] = 1'b1;
    end

    if (issue_fire) begin
      valid_d[grant_addr] = 1'b0;
      age_d[grant_addr]   = '0;
    end

    // The dispatch slot is always invalid, so it never collides with the grant.
    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = disp_op;
      psrc1_d[free_idx] = disp_psrc1;
      psrc2_d[free_idx] = disp_psrc2;
      pdst_d[free_idx]  = disp_pdst;
      rdy1_d[free_idx]  = disp_rdy1;
      rdy2_d[free_idx]  = disp_rdy2;
      age_d[free_idx]   = disp_age;
    end

    if (flush) begin
      valid_d = '0;
      age_d   = '{default: '0};
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      op_q    <= '{default: '0};
      psrc1_q <= '{default: '0};
      psrc2_q <= '{default: '0};
      pdst_q  <= '{default: '0};
      age_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      op_q    <= op_d;
      psrc1_q <= psrc1_d;
      psrc2_q <= psrc2_d;
      pdst_q  <= pdst_d;
      age_q   <= age_d;
      count_q <= count_d;
    end
  end

  // Issue payload is combinational from the grant; a flush does not gate it.
  assign iss_valid = issue_fire;
  assign iss_op    = issue_fire ? op_q[grant_addr]    : '0;
  assign iss_psrc1 = issue_fire ? psrc1_q[grant_addr] : '0;
  assign iss_psrc2 = issue_fire ? psrc2_q[grant_addr] : '0;
  assign iss_pdst  = issue_fire ? pdst_q[grant_addr]  : '0;
  assign count     = count_q;

endmodule

`default_nettype wire
